// File: rtl/ext_pkg.sv
// Shared immediate-extension mode constants and the occupancy encoding used by
// the registered extension stage.
package ext_pkg;

    localparam logic [1:0] EXT_ZERO   = 2'b00;
    localparam logic [1:0] EXT_SIGN   = 2'b01;
    localparam logic [1:0] EXT_UPPER  = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extender: ZERO, SIGN, UPPER (LUI) and BRANCH (sext<<2).
// Usable standalone by the decoder as well as inside the registered stage.
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] ext_o
);

    localparam int S = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;

    assign sext[IN_W-1:0] = imm_i;

    genvar gi;
    generate
        for (gi = IN_W; gi < OUT_W; gi++) begin : g_sign
            assign sext[gi] = imm_i[IN_W-1];
        end
    endgenerate

    always_comb begin
        ext_o = '0;
        case (mode_i)
            EXT_ZERO:   ext_o = {{S{1'b0}}, imm_i};
            EXT_SIGN:   ext_o = sext;
            EXT_UPPER:  ext_o = {imm_i, {S{1'b0}}};
            // Top two bits of the sign-extended value fall off the end.
            EXT_BRANCH: ext_o = {sext[OUT_W-3:0], 2'b00};
            default:    ext_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with a two-entry skid buffer, tag sideband
// and flush. Extension happens before storage so entries hold the final operand.
module imm_extend_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [IN_W-1:0]  InImm,
    input  logic [1:0]       InMode,
    input  logic [TAG_W-1:0] InTag,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [OUT_W-1:0] OutImm,
    output logic [TAG_W-1:0] OutTag
);

    generate
        if (IN_W < 2 || OUT_W < IN_W + 2) begin : g_bad_params
            $error("imm_extend_pipe: need IN_W >= 2 and OUT_W >= IN_W + 2");
        end
    endgenerate

    occ_e             state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] main_imm_q, main_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic [OUT_W-1:0] skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    logic [OUT_W-1:0] ext_val;
    logic             in_xfer;
    logic             out_xfer;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext_core (
        .imm_i  (InImm),
        .mode_i (InMode),
        .ext_o  (ext_val)
    );

    assign in_xfer  = InValid & in_ready_q;
    assign out_xfer = out_valid_q & OutReady;

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;

        // Flush drops everything buffered; any simultaneous input is ignored.
        if (Flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (in_xfer) begin
                        main_imm_d = ext_val;
                        main_tag_d = InTag;
                        state_d    = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_imm_d = ext_val;
                        main_tag_d = InTag;
                    end else if (in_xfer) begin
                        skid_imm_d = ext_val;
                        skid_tag_d = InTag;
                        state_d    = OCC_FULL;
                    end else if (out_xfer) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (out_xfer) begin
                        main_imm_d = skid_imm_q;
                        main_tag_d = skid_tag_q;
                        state_d    = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end

        in_ready_d  = (state_d != OCC_FULL);
        out_valid_d = (state_d != OCC_EMPTY);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= OCC_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_imm_q  <= '0;
            main_tag_q  <= '0;
            skid_imm_q  <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_imm_q  <= main_imm_d;
            main_tag_q  <= main_tag_d;
            skid_imm_q  <= skid_imm_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = out_valid_q;
    assign OutImm   = main_imm_q;
    assign OutTag   = main_tag_q;

endmodule
